// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table and
// the all-off values for cathodes and anodes.
package seg_pkg;

    // Active-low g..a patterns for hex digits 0..F; bit 7 (dp) is added by the driver.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/seven_seg_driver_if.sv
// Host-side bundle of the seven-segment driver: load strobe with data,
// blanking control, and the display pins coming back.
interface seven_seg_driver_if;
    // Handshake: load is a valid-only strobe with no ready; every cycle it is high
    // data_in/dp_in are captured into the shadow, and pending reports that the
    // capture has not yet reached the display at a frame boundary.
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic        pending;
    logic [7:0]  segs;
    logic [3:0]  an;

    modport master (
        output data_in, dp_in, load, blank_lz,
        input  pending, segs, an
    );

    modport slave (
        input  data_in, dp_in, load, blank_lz,
        output pending, segs, an
    );
endinterface

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low g..a segment pattern.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_pat
);

    assign o_pat = SEG_TABLE[i_nib];

endmodule

// File: rtl/seven_seg_driver.sv
// Four-digit multiplexed seven-segment driver with a double-buffered display
// register that only updates on frame boundaries, plus leading-zero blanking.
module seven_seg_driver
    import seg_pkg::*;
#(
    parameter int CLK_DIV    = 50000,
    parameter int NUM_DIGITS = 4
)
(
    input  logic               clk,
    input  logic               rst_n,
    seven_seg_driver_if.slave  bus
);

    localparam int             PW        = $clog2(CLK_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [1:0]     IDX_LAST  = 2'(NUM_DIGITS - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_shadow;
    logic [3:0]    r_shadow_dp;
    logic [15:0]   r_disp;
    logic [3:0]    r_disp_dp;
    logic          r_pending;
    logic [7:0]    r_segs;
    logic [3:0]    r_an;

    logic          w_tick;
    logic          w_frame;
    logic [3:0]    w_nib;
    logic [6:0]    w_pat;
    logic          w_blank;

    assign w_tick  = (r_presc == PRESC_MAX);
    assign w_frame = w_tick && (r_idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // A load on the boundary tick still commits the previous shadow, because the
    // display copy reads r_shadow before this edge overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow    <= 16'h0;
            r_shadow_dp <= 4'h0;
            r_disp      <= 16'h0;
            r_disp_dp   <= 4'h0;
            r_pending   <= 1'b0;
        end else begin
            if (bus.load) begin
                r_shadow    <= bus.data_in;
                r_shadow_dp <= bus.dp_in;
            end
            if (w_frame && r_pending) begin
                r_disp    <= r_shadow;
                r_disp_dp <= r_shadow_dp;
            end
            if (bus.load) begin
                r_pending <= 1'b1;
            end else if (w_frame) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign w_nib = r_disp[{r_idx, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .i_nib (w_nib),
        .o_pat (w_pat)
    );

    // A digit is a leading zero when it and every more significant nibble are 0.
    always_comb begin
        w_blank = 1'b0;
        if (bus.blank_lz) begin
            case (r_idx)
                2'd1:    w_blank = (r_disp[15:4]  == 12'h0);
                2'd2:    w_blank = (r_disp[15:8]  == 8'h0);
                2'd3:    w_blank = (r_disp[15:12] == 4'h0);
                default: w_blank = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segs <= SEG_BLANK;
            r_an   <= AN_OFF;
        end else if (w_blank) begin
            r_segs <= SEG_BLANK;
            r_an   <= AN_OFF;
        end else begin
            r_segs <= {~r_disp_dp[r_idx], w_pat};
            r_an   <= ~(4'b0001 << r_idx);
        end
    end

    assign bus.segs    = r_segs;
    assign bus.an      = r_an;
    assign bus.pending = r_pending;

endmodule

// File: tb/tb_seven_seg_driver.sv
// Bench for seven_seg_driver at CLK_DIV=4: each scenario pushes the expected
// {an,segs} per cycle into a queue and pops/compares as the scan runs.
module tb_seven_seg_driver;

    localparam logic [7:0] TBL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    logic [11:0] exp_q [$];

    seven_seg_driver_if bus ();

    seven_seg_driver #(.CLK_DIV(4), .NUM_DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges since reset was released
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ---------------- model / drivers ----------------
    function automatic logic [11:0] exp_out(input logic [15:0] v, input logic [3:0] dp,
                                            input logic blz, input int slot);
        logic [15:0] upper;
        logic [7:0]  p;
        upper = v >> (4 * slot);
        p     = TBL[upper[3:0]];
        if (blz && slot != 0 && upper == 16'h0) return {4'hF, 8'hFF};
        return {~(4'b0001 << slot), ~dp[slot], p[6:0]};
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input logic blz);
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 4; k++)
                exp_q.push_back(exp_out(v, dp, blz, s));
    endtask

    task automatic do_reset(input logic blz);
        rst_n        = 1'b0;
        bus.load     = 1'b0;
        bus.data_in  = 16'h0;
        bus.dp_in    = 4'h0;
        bus.blank_lz = blz;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_load(input logic [15:0] v, input logic [3:0] dp);
        bus.load    = 1'b1;
        bus.data_in = v;
        bus.dp_in   = dp;
    endtask

    task automatic wait_to(input int n);
        int t;
        t = 0;
        while (cyc < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (cyc < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout waiting for cycle %0d, at %0d", n, cyc);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [11:0] e;
        rst_n = 1'b0;
        bus.load = 1'b0; bus.data_in = 16'h0; bus.dp_in = 4'h0; bus.blank_lz = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.an !== 4'hF) begin n_fail++; $display("FAIL reset_an got=%h exp=f", bus.an); end
        n_checks++;
        if (bus.segs !== 8'hFF) begin n_fail++; $display("FAIL reset_segs got=%h exp=ff", bus.segs); end
        n_checks++;
        if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got=%b exp=0", bus.pending); end
        rst_n = 1'b1;
        push_frame(16'h0, 4'h0, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            wait_to(c);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hxxx;
            n_checks++;
            if ({bus.an, bus.segs} !== e) begin
                n_fail++; $display("FAIL reset_scan cyc=%0d got=%h exp=%h", c, {bus.an, bus.segs}, e);
            end
        end
    endtask

    task automatic test_load_1234();
        logic [11:0] e;
        logic        ep;
        do_reset(1'b0);
        push_frame(16'h0, 4'h0, 1'b0);
        for (int c = 0; c <= 32; c++) begin
            wait_to(c);
            if (c >= 1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hxxx;
                n_checks++;
                if ({bus.an, bus.segs} !== e) begin
                    n_fail++; $display("FAIL load_1234 cyc=%0d got=%h exp=%h", c, {bus.an, bus.segs}, e);
                end
                ep = (c <= 15);
                n_checks++;
                if (bus.pending !== ep) begin
                    n_fail++; $display("FAIL load_1234_pending cyc=%0d got=%b exp=%b", c, bus.pending, ep);
                end
            end
            bus.load = 1'b0;
            if (c == 0) begin drive_load(16'h1234, 4'h0); push_frame(16'h1234, 4'h0, 1'b0); end
        end
    endtask

    task automatic test_blank();
        logic [11:0] e;
        do_reset(1'b1);
        push_frame(16'h0, 4'h0, 1'b1);
        for (int c = 0; c <= 48; c++) begin
            wait_to(c);
            if (c >= 1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hxxx;
                n_checks++;
                if ({bus.an, bus.segs} !== e) begin
                    n_fail++; $display("FAIL blank_lz cyc=%0d got=%h exp=%h", c, {bus.an, bus.segs}, e);
                end
            end
            bus.load = 1'b0;
            if (c == 0)  begin drive_load(16'h0005, 4'h0);    push_frame(16'h0005, 4'h0, 1'b1); end
            if (c == 19) begin drive_load(16'h0F00, 4'b0101); push_frame(16'h0F00, 4'b0101, 1'b1); end
        end
    endtask

    task automatic test_mid_frame();
        logic [11:0] e;
        logic        ep;
        do_reset(1'b0);
        push_frame(16'h0, 4'h0, 1'b0);
        for (int c = 0; c <= 48; c++) begin
            wait_to(c);
            if (c >= 1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hxxx;
                n_checks++;
                if ({bus.an, bus.segs} !== e) begin
                    n_fail++; $display("FAIL mid_frame cyc=%0d got=%h exp=%h", c, {bus.an, bus.segs}, e);
                end
                ep = (c <= 15) || (c >= 22 && c <= 31);
                n_checks++;
                if (bus.pending !== ep) begin
                    n_fail++; $display("FAIL mid_frame_pending cyc=%0d got=%b exp=%b", c, bus.pending, ep);
                end
            end
            bus.load = 1'b0;
            if (c == 0)  begin drive_load(16'h1234, 4'h0); push_frame(16'h1234, 4'h0, 1'b0); end
            if (c == 21) begin drive_load(16'hABCD, 4'h0); push_frame(16'hABCD, 4'h0, 1'b0); end
        end
    endtask

    task automatic test_boundary_load();
        logic [11:0] e;
        logic        ep;
        do_reset(1'b0);
        push_frame(16'h0, 4'h0, 1'b0);
        for (int c = 0; c <= 48; c++) begin
            wait_to(c);
            if (c >= 1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hxxx;
                n_checks++;
                if ({bus.an, bus.segs} !== e) begin
                    n_fail++; $display("FAIL boundary_load cyc=%0d got=%h exp=%h", c, {bus.an, bus.segs}, e);
                end
                ep = (c >= 10 && c <= 31);
                n_checks++;
                if (bus.pending !== ep) begin
                    n_fail++; $display("FAIL boundary_pending cyc=%0d got=%b exp=%b", c, bus.pending, ep);
                end
            end
            bus.load = 1'b0;
            if (c == 9)  begin drive_load(16'h1111, 4'h0); push_frame(16'h1111, 4'h0, 1'b0); end
            if (c == 15) begin drive_load(16'h5555, 4'h0); push_frame(16'h5555, 4'h0, 1'b0); end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        do_reset(1'b0);
        push_frame(16'h0, 4'h0, 1'b0);
        for (int c = 0; c <= 32; c++) begin
            wait_to(c);
            if (c >= 1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hxxx;
                n_checks++;
                if ({bus.an, bus.segs} !== e) begin
                    n_fail++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, {bus.an, bus.segs}, e);
                end
            end
            bus.load = 1'b0;
            if (c == 2) drive_load(16'h1111, 4'hF);
            if (c == 3) drive_load(16'h2222, 4'h0);
            if (c == 8) begin drive_load(16'h3333, 4'b1010); push_frame(16'h3333, 4'b1010, 1'b0); end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] e;
        do_reset(1'b0);
        push_frame(16'h0, 4'h0, 1'b0);
        for (int c = 0; c <= 25; c++) begin
            wait_to(c);
            if (c >= 1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hxxx;
                n_checks++;
                if ({bus.an, bus.segs} !== e) begin
                    n_fail++; $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", c, {bus.an, bus.segs}, e);
                end
            end
            bus.load = 1'b0;
            if (c == 0)  begin drive_load(16'h1234, 4'h0); push_frame(16'h1234, 4'h0, 1'b0); end
            if (c == 19) drive_load(16'h9876, 4'hF);
        end
        // now in digit-2 slot of frame 1 with 0x9876 pending
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.pending, bus.an, bus.segs} !== {1'b0, 4'hF, 8'hFF}) begin
            n_fail++; $display("FAIL reset_mid_async got=%h exp=%h", {bus.pending, bus.an, bus.segs}, {1'b0, 4'hF, 8'hFF});
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_frame(16'h0, 4'h0, 1'b0);
        push_frame(16'h0, 4'h0, 1'b0);
        for (int c = 1; c <= 32; c++) begin
            wait_to(c);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hxxx;
            n_checks++;
            if ({bus.pending, bus.an, bus.segs} !== {1'b0, e}) begin
                n_fail++; $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", c, {bus.pending, bus.an, bus.segs}, {1'b0, e});
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] e;
        logic        blz;
        int          ld_edge [4];
        logic [15:0] ld_val  [4];
        logic [3:0]  ld_dp   [4];
        blz = 1'($urandom_range(0, 1));
        for (int f = 0; f < 4; f++) begin
            ld_edge[f] = 16 * f + int'($urandom_range(1, 15));
            ld_val[f]  = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
            ld_dp[f]   = 4'($urandom_range(0, 15));
        end
        do_reset(blz);
        push_frame(16'h0, 4'h0, blz);
        for (int c = 0; c <= 80; c++) begin
            wait_to(c);
            if (c >= 1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hxxx;
                n_checks++;
                if ({bus.an, bus.segs} !== e) begin
                    n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", c, {bus.an, bus.segs}, e);
                end
            end
            bus.load = 1'b0;
            for (int f = 0; f < 4; f++) begin
                if (c + 1 == ld_edge[f]) begin
                    drive_load(ld_val[f], ld_dp[f]);
                    push_frame(ld_val[f], ld_dp[f], blz);
                end
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        test_reset();
        test_load_1234();
        test_blank();
        test_mid_frame();
        test_boundary_load();
        test_back_to_back();
        test_reset_mid();
        for (int r = 0; r < 3; r++) test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_driver.md
SEVEN_SEG_DRIVER -- requirements
Module: seven_seg_driver

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50000, giving the number of clk cycles each digit is lit (range 2..2^20).
REQ-002 The block SHALL have parameter NUM_DIGITS, default 4, fixed at 4 for this revision.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 data_in  input  16  four hex nibbles to display; nibble 0 = bits [3:0] = rightmost digit.
REQ-007 dp_in  input  4  decimal-point enables, one per digit, bit i = digit i.
REQ-008 load  input  1  single-cycle strobe; captures data_in and dp_in.
REQ-009 blank_lz  input  1  leading-zero blanking enable, sampled live.
REQ-010 pending  output  1  high while captured data awaits the frame boundary.
REQ-011 segs  output  8  active-low cathodes; [7]=dp, [6:0]=g..a.
REQ-012 an  output  4  active-low anodes; an[i] lights digit i.

Function
REQ-013 A prescaler SHALL count 0..CLK_DIV-1 and wrap; tick is high on the cycle the count equals CLK_DIV-1.
REQ-014 On tick, the digit index SHALL advance 0->1->2->3->0.
REQ-015 A frame boundary SHALL be the tick that wraps the index from 3 to 0.
REQ-016 On load, data_in/dp_in SHALL be written into a shadow register and pending SHALL set the next cycle.
REQ-017 At a frame boundary with pending=1, the shadow SHALL copy into the display register and pending SHALL clear.
REQ-018 Displayed data SHALL never change mid-frame, so there is no tearing.
REQ-019 If load coincides with a frame boundary, the OLD shadow SHALL commit, the new data SHALL enter the shadow, and pending SHALL remain 1.
REQ-020 Back-to-back loads within one frame SHALL overwrite the shadow; only the last value commits.
REQ-021 segs/an SHALL be registered from the current index and display register, with exactly one cycle of latency after an index change.
REQ-022 Exactly one an bit SHALL be low at any time outside reset, unless that digit is blanked.
REQ-023 With blank_lz=1, digit i (i=3..1) SHALL be blanked (an[i]=1, segs=8'hFF) when its nibble and all higher nibbles are 0.
REQ-024 Digit 0 SHALL never be blanked.
REQ-025 Segment patterns SHALL be the standard active-low hex set: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
REQ-026 segs[7] SHALL be cleared to light the dp when the dp bit of the displayed digit is 1.

Reset
REQ-027 While rst_n=0, the block SHALL hold: prescaler=0, index=0, shadow=0, display=0, dp regs=0, pending=0, an=4'b1111, segs=8'hFF.
REQ-028 On the first clk edge after rst_n rises, the block SHALL drive an=4'b1110 and segs=8'hC0.
REQ-029 Reset asserted mid-scan or with pending=1 SHALL discard the shadow, with no commit.

Structure
REQ-030 Package seg_pkg SHALL hold the 16-entry segment pattern constant table, SEG_BLANK=8'hFF and AN_OFF=4'hF.
REQ-031 Sub-module hex7seg SHALL be purely combinational (4-bit nibble in, 7-bit pattern out), instantiated once on the muxed nibble.
REQ-032 The prescaler width SHALL be $clog2(CLK_DIV).

Verification (CLK_DIV=4)
REQ-033 Reset: hold rst_n=0 -> an=1111, segs=FF, pending=0; release -> next edge an=1110, segs=C0.
REQ-034 Load 0x1234 at frame start -> pending=1 until the boundary; the next frame shows an 1110/1101/1011/0111 with segs 99/B0/A4/F9, each held 4 cycles.
REQ-035 blank_lz=1, load 0x0005 -> an[0] only, segs=92; an=1111 and segs=FF during the digit 1..3 slots.
REQ-036 Load 0xABCD mid-frame while 0x1234 is displayed -> the remaining digits of the current frame still show 0x1234; 0xABCD appears from the next digit-0 slot.
REQ-037 Load 0x5555 on the boundary tick with shadow=0x1111 -> the next frame shows 1111 with pending=1; the following frame shows 5555.
REQ-038 Assert rst_n low during digit 2 with pending=1 -> all outputs return to reset values at once; after release, digit 0 shows 0 and pending=0.
